// File: rtl/ifm_row_loader_if.sv
// Memory read port and line-buffer write port of the IFM row loader.
// The master side is the loader; the slave side is memory plus buffer.
interface ifm_row_loader_if #(
  parameter int W_ADDR     = 32,
  parameter int W_DATA     = 32,
  parameter int W_BUF_ADDR = 12
);
  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [W_ADDR-1:0]     rd_addr;
  logic [7:0]            rd_len;
  logic                  rd_data_valid;
  logic [W_DATA-1:0]     rd_data;
  logic                  rd_data_ready;
  logic                  buf_we;
  logic [1:0]            buf_bank;
  logic [W_BUF_ADDR-1:0] buf_addr;
  logic [W_DATA-1:0]     buf_wdata;

  modport master (
    output rd_req_valid, rd_addr, rd_len, rd_data_ready,
    output buf_we, buf_bank, buf_addr, buf_wdata,
    input  rd_req_ready, rd_data_valid, rd_data
  );

  modport slave (
    input  rd_req_valid, rd_addr, rd_len, rd_data_ready,
    input  buf_we, buf_bank, buf_addr, buf_wdata,
    output rd_req_ready, rd_data_valid, rd_data
  );
endinterface

// File: rtl/ifm_row_loader.sv
// Loads one IFM row from external memory in bursts of up to MAX_BURST words
// and writes it, in memory order, into line-buffer bank row[1:0].
module ifm_row_loader #(
  parameter int W_SIZE     = 10,
  parameter int W_CHANNEL  = 8,
  parameter int W_ADDR     = 32,
  parameter int W_DATA     = 32,
  parameter int W_BUF_ADDR = 12,
  parameter int MAX_BURST  = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_req_load,
  input  logic [W_SIZE-1:0]    i_req_row,
  input  logic [W_SIZE-1:0]    i_width,
  input  logic [W_CHANNEL-1:0] i_channel,
  input  logic [W_ADDR-1:0]    i_base_addr,
  output logic                 o_req_done,
  output logic                 o_busy,
  ifm_row_loader_if.master     m_if
);
  localparam int W_WORDS = W_SIZE + W_CHANNEL;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CALC  = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]            r_state;
  logic [W_SIZE-1:0]     r_row;
  logic [W_SIZE-1:0]     r_width;
  logic [W_CHANNEL-1:0]  r_channel;
  logic [W_ADDR-1:0]     r_base;
  logic [W_WORDS-1:0]    r_remaining;
  logic [W_BUF_ADDR-1:0] r_word_idx;
  logic [7:0]            r_beat_cnt;
  logic [W_ADDR-1:0]     r_rd_addr;
  logic [7:0]            r_rd_len;
  logic                  r_buf_we;
  logic [1:0]            r_buf_bank;
  logic [W_BUF_ADDR-1:0] r_buf_addr;
  logic [W_DATA-1:0]     r_buf_wdata;

  logic [W_WORDS-1:0]    w_row_words;
  logic [W_ADDR-1:0]     w_row_addr;
  logic                  w_beat_acc;

  // Burst length field (beats minus one) for n outstanding words, n >= 1.
  function automatic logic [7:0] burst_len(input logic [W_WORDS-1:0] n);
    if (n > W_WORDS'(MAX_BURST)) begin
      burst_len = 8'(MAX_BURST - 1);
    end else begin
      burst_len = 8'(n - W_WORDS'(1));
    end
  endfunction

  assign w_row_words = W_WORDS'(r_width) * W_WORDS'(r_channel);
  assign w_row_addr  = r_base + ((W_ADDR'(r_row) * W_ADDR'(w_row_words)) << 2'd2);
  assign w_beat_acc  = (r_state == S_DATA) && m_if.rd_data_valid;

  // Control outputs are decodes of the state register only.
  assign o_busy             = (r_state != S_IDLE);
  assign o_req_done         = (r_state == S_DONE);
  assign m_if.rd_req_valid  = (r_state == S_REQ);
  assign m_if.rd_data_ready = (r_state == S_DATA);
  assign m_if.rd_addr       = r_rd_addr;
  assign m_if.rd_len        = r_rd_len;
  assign m_if.buf_we        = r_buf_we;
  assign m_if.buf_bank      = r_buf_bank;
  assign m_if.buf_addr      = r_buf_addr;
  assign m_if.buf_wdata     = r_buf_wdata;

  // Row-load FSM with burst address generation and buffer write stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_width     <= '0;
      r_channel   <= '0;
      r_base      <= '0;
      r_remaining <= '0;
      r_word_idx  <= '0;
      r_beat_cnt  <= 8'd0;
      r_rd_addr   <= '0;
      r_rd_len    <= 8'd0;
      r_buf_we    <= 1'b0;
      r_buf_bank  <= 2'd0;
      r_buf_addr  <= '0;
      r_buf_wdata <= '0;
    end else begin
      r_buf_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_load) begin
            r_row      <= i_req_row;
            r_width    <= i_width;
            r_channel  <= i_channel;
            r_base     <= i_base_addr;
            r_buf_bank <= i_req_row[1:0];
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_rd_addr   <= w_row_addr;
          r_remaining <= w_row_words;
          r_word_idx  <= '0;
          if (w_row_words == '0) begin
            r_state <= S_DONE;
          end else begin
            r_rd_len <= burst_len(w_row_words);
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (m_if.rd_req_ready) begin
            r_beat_cnt <= r_rd_len;
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_beat_acc) begin
            r_buf_we    <= 1'b1;
            r_buf_addr  <= r_word_idx;
            r_buf_wdata <= m_if.rd_data;
            r_word_idx  <= r_word_idx + W_BUF_ADDR'(1);
            r_remaining <= r_remaining - W_WORDS'(1);
            r_beat_cnt  <= r_beat_cnt - 8'd1;
            if (r_beat_cnt == 8'd0) begin
              // Extra DRAIN cycle lets the final buffer write land before done.
              if (r_remaining == W_WORDS'(1)) begin
                r_state <= S_DRAIN;
              end else begin
                r_rd_addr <= r_rd_addr + ((W_ADDR'(r_rd_len) + W_ADDR'(1)) << 2'd2);
                r_rd_len  <= burst_len(r_remaining - W_WORDS'(1));
                r_state   <= S_REQ;
              end
            end
          end
        end
        S_DRAIN: r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ifm_row_loader.sv
// Randomized bench for ifm_row_loader: a memory responder plus a queue-based
// reference model of the expected bursts, buffer writes and done timing.
module tb_ifm_row_loader;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_req_load;
  logic [9:0]  i_req_row;
  logic [9:0]  i_width;
  logic [7:0]  i_channel;
  logic [31:0] i_base_addr;
  logic        o_req_done;
  logic        o_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  ifm_row_loader_if #(.W_ADDR(32), .W_DATA(32), .W_BUF_ADDR(12)) u_if ();

  ifm_row_loader dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_req_load  (i_req_load),
    .i_req_row   (i_req_row),
    .i_width     (i_width),
    .i_channel   (i_channel),
    .i_base_addr (i_base_addr),
    .o_req_done  (o_req_done),
    .o_busy      (o_busy),
    .m_if        (u_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [9:0] all_out_or();
    return {o_req_done, o_busy, u_if.rd_req_valid, u_if.rd_data_ready, u_if.buf_we,
            |u_if.buf_bank, |u_if.buf_addr, |u_if.buf_wdata, |u_if.rd_addr, |u_if.rd_len};
  endfunction

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_quiet", {o_busy, u_if.rd_req_valid, u_if.buf_we, o_req_done}, 4'd0);
      tick();
    end
  endtask

  // Issues a request at the current negedge and services it to completion.
  // abort_beats > 0: assert reset mid-burst after that many beats.
  task automatic do_row(input int row, input int w, input int c, input logic [31:0] base,
                        input int ready_hold, input int gap_pct, input bit ign_pulse,
                        input int abort_beats);
    int          words;
    logic [31:0] row_addr;
    logic [31:0] q_baddr[$];
    int          q_blen[$];
    logic [31:0] beat_addr[$];
    logic [31:0] a;
    logic [31:0] held_addr;
    logic [7:0]  held_len;
    int          rem, n, k_wr, t_req, first_valid, last_beat, done_cyc, n_done;
    int          wait_cnt, beats_acc;
    bit          waiting, pulsed, finished;

    words    = w * c;
    row_addr = base + 32'(row) * 32'(words) * 32'd4;
    a = row_addr;
    rem = words;
    while (rem > 0) begin
      n = (rem > 16) ? 16 : rem;
      q_baddr.push_back(a);
      q_blen.push_back(n - 1);
      a = a + 32'(n) * 32'd4;
      rem = rem - n;
    end
    k_wr = 0; first_valid = -1; last_beat = -1; done_cyc = -1; n_done = 0;
    wait_cnt = 0; beats_acc = 0; waiting = 1'b0; pulsed = 1'b0; finished = 1'b0;

    i_req_load  = 1'b1;
    i_req_row   = 10'(row);
    i_width     = 10'(w);
    i_channel   = 8'(c);
    i_base_addr = base;
    t_req = cyc;
    tick();
    i_req_load  = 1'b0;
    i_req_row   = 10'($urandom);
    i_width     = 10'($urandom);
    i_channel   = 8'($urandom);
    i_base_addr = $urandom;

    for (int it = 0; it < 2000; it++) begin
      if (abort_beats > 0 && beats_acc >= abort_beats && beat_addr.size() > 0) begin
        rstn = 1'b0;
        i_req_load = 1'b0;
        u_if.rd_req_ready  = 1'b0;
        u_if.rd_data_valid = 1'b0;
        #1;
        chk("rst_mid_outs", 64'(all_out_or()), 64'd0);
        tick();
        tick();
        chk("rst_hold_outs", 64'(all_out_or()), 64'd0);
        rstn = 1'b1;
        tick();
        return;
      end
      if (u_if.buf_we) begin
        chk("wr_bank", 64'(u_if.buf_bank), 64'(row % 4));
        chk("wr_addr", 64'(u_if.buf_addr), 64'(k_wr));
        chk("wr_data", 64'(u_if.buf_wdata), 64'(mem_word(row_addr + 32'(k_wr) * 32'd4)));
        k_wr++;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("busy_drop", 64'(o_busy), 64'd0);
        finished = 1'b1;
        break;
      end
      if (o_req_done) begin
        n_done++;
        done_cyc = cyc;
        chk("done_time", 64'(cyc), 64'((words == 0) ? t_req + 2 : last_beat + 2));
      end
      chk("busy_during", 64'(o_busy), 64'd1);

      u_if.rd_req_ready = 1'b0;
      if (u_if.rd_req_valid) begin
        if (first_valid < 0) begin
          first_valid = cyc;
          chk("first_valid_time", 64'(cyc), 64'(t_req + 2));
        end
        if (!waiting) begin
          waiting = 1'b1;
          wait_cnt = 0;
          held_addr = u_if.rd_addr;
          held_len  = u_if.rd_len;
        end else begin
          chk("req_stable", {u_if.rd_addr, 24'd0, u_if.rd_len}, {held_addr, 24'd0, held_len});
        end
        if (wait_cnt >= ready_hold) begin
          u_if.rd_req_ready = 1'b1;
          waiting = 1'b0;
          if (q_baddr.size() == 0) begin
            chk("extra_burst", 64'd1, 64'd0);
          end else begin
            chk("burst_addr", 64'(u_if.rd_addr), 64'(q_baddr[0]));
            chk("burst_len", 64'(u_if.rd_len), 64'(q_blen[0]));
            for (int j = 0; j <= q_blen[0]; j++) beat_addr.push_back(q_baddr[0] + 32'(j) * 32'd4);
            void'(q_baddr.pop_front());
            void'(q_blen.pop_front());
          end
        end
        wait_cnt++;
      end

      u_if.rd_data_valid = 1'b0;
      u_if.rd_data       = $urandom;
      if (u_if.rd_data_ready && beat_addr.size() > 0) begin
        if ($urandom_range(99) >= gap_pct) begin
          u_if.rd_data_valid = 1'b1;
          u_if.rd_data       = mem_word(beat_addr[0]);
          void'(beat_addr.pop_front());
          beats_acc++;
          if (q_baddr.size() == 0 && beat_addr.size() == 0) last_beat = cyc;
        end
      end else if (!u_if.rd_data_ready && $urandom_range(3) == 0) begin
        u_if.rd_data_valid = 1'b1;
      end

      i_req_load = 1'b0;
      if (ign_pulse && !pulsed && u_if.rd_data_ready) begin
        i_req_load = 1'b1;
        i_req_row  = 10'd7;
        pulsed     = 1'b1;
      end
      tick();
    end
    i_req_load = 1'b0;
    u_if.rd_req_ready  = 1'b0;
    u_if.rd_data_valid = 1'b0;
    chk("row_finished", 64'(finished), 64'd1);
    chk("done_count", 64'(n_done), 64'd1);
    chk("write_count", 64'(k_wr), 64'(words));
    chk("bursts_left", 64'(q_baddr.size()), 64'd0);
    if (words == 0) chk("no_rd_req", 64'(first_valid < 0), 64'd1);
  endtask

  initial begin
    i_req_load = 1'b0; i_req_row = 10'd0; i_width = 10'd0; i_channel = 8'd0;
    i_base_addr = 32'd0;
    u_if.rd_req_ready = 1'b0; u_if.rd_data_valid = 1'b0; u_if.rd_data = 32'd0;
    tick();
    tick();
    chk("reset_outs", 64'(all_out_or()), 64'd0);
    rstn = 1'b1;
    tick();
    chk("idle_after_reset", 64'(all_out_or()), 64'd0);

    do_row(3, 4, 2, 32'h0000_1000, 0, 0, 1'b0, 0);
    do_row(1, 10, 4, 32'h0000_0000, 0, 0, 1'b0, 0);
    do_row(6, 7, 3, 32'h0004_0000, 5, 40, 1'b0, 0);
    do_row(5, 0, 3, 32'h0000_2000, 0, 0, 1'b0, 0);
    do_row(9, 7, 0, 32'h0000_2000, 0, 0, 1'b0, 0);
    idle_check(2);
    do_row(0, 6, 3, 32'h0000_2000, 1, 20, 1'b1, 0);
    idle_check(4);
    do_row(1, 10, 4, 32'h0000_0400, 0, 10, 1'b0, 5);
    do_row(2, 5, 3, 32'h0000_0400, 0, 10, 1'b0, 0);
    for (int r = 0; r < 12; r++) begin
      do_row($urandom_range(1023), $urandom_range(12), $urandom_range(6),
             {$urandom_range(32'h0FFF_FFFF), 2'b00}, $urandom_range(3),
             $urandom_range(50), 1'b0, 0);
    end
    idle_check(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ifm_row_loader.md
# ifm_row_loader

Responder side of the IFM row-load handshake issued by the CNN controller. It accepts a one-cycle row load request, reads that feature-map row from external memory as one or more read bursts, and writes the words into one bank of a 4-bank IFM line buffer. When the last word of the row has been written, it pulses `o_req_done`. It sits between the controller and the memory read port and owns all IFM address generation.

## Interface
- `W_SIZE`, default 10: width of row/width fields.
- `W_CHANNEL`, default 8: width of the tiled-channel field.
- `W_ADDR`, default 32: byte address width.
- `W_DATA`, default 32: word width (4 bytes per word).
- `W_BUF_ADDR`, default 12: word address width within one buffer bank.
- `MAX_BURST`, default 16: maximum beats per read burst.

Ports (reset rstn, asynchronous, active-low; clock clk):
- `clk`  in  1  clock
- `rstn`  in  1  asynchronous active-low reset
- `i_req_load`  in  1  one-cycle load request
- `i_req_row`  in  W_SIZE  row to load, sampled with `i_req_load`
- `i_width`  in  W_SIZE  columns per row
- `i_channel`  in  W_CHANNEL  tiled channels per row
- `i_base_addr`  in  W_ADDR  byte address of row 0, word aligned
- `o_req_done`  out  1  one-cycle pulse; the row is fully written
- `o_busy`  out  1  high from request accept until `o_req_done`, inclusive
- `o_rd_req_valid`  out  1  burst request valid
- `i_rd_req_ready`  in  1  burst request accepted
- `o_rd_addr`  out  W_ADDR  burst start byte address
- `o_rd_len`  out  8  beats minus 1
- `i_rd_data_valid`  in  1  read beat valid
- `i_rd_data`  in  W_DATA  read beat data
- `o_rd_data_ready`  out  1  beat accept; high only in DATA state
- `o_buf_we`  out  1  buffer write enable
- `o_buf_bank`  out  2  target bank = `i_req_row[1:0]`
- `o_buf_addr`  out  W_BUF_ADDR  word index in bank
- `o_buf_wdata`  out  W_DATA  write data

## Operation
- Row size: `row_words = i_width * i_channel`, computed at W_SIZE+W_CHANNEL bits. `i_width`, `i_channel` and `i_base_addr` are latched on request accept.
- Row address: `row_addr = base + row * row_words * 4`, computed modulo 2^W_ADDR.
- Word order follows memory order. Word k is element (col = k mod width, chn = k div width), col fastest, matching the controller scan. Word k is written to `o_buf_addr = k`.
- FSM states:
  - IDLE: if `i_req_load`, latch the inputs and go to CALC.
  - CALC: one cycle to register `row_addr` and `remaining = row_words`. If `row_words == 0`, go to DONE; otherwise go to REQ.
  - REQ: `o_rd_req_valid = 1` with stable `o_rd_addr` and `o_rd_len = min(remaining, MAX_BURST) - 1`. When valid && ready, go to DATA.
  - DATA: accept beats on `i_rd_data_valid`. Each accepted beat decrements `remaining` and increments the word index. After the last beat of a burst: if `remaining > 0`, go to REQ with addr += beats*4; otherwise go to DONE.
  - DONE: `o_req_done = 1` for one cycle, then go to IDLE.
- At most one burst is outstanding.
- `i_req_load` outside IDLE is ignored: no latch and no effect.
- Extra `i_rd_data_valid` outside DATA is not accepted, because `o_rd_data_ready = 0`.

## Timing
- Reset values: all outputs 0; FSM in IDLE; internal counters 0.
- Reset mid-operation returns the block to IDLE immediately. No done pulse is issued, and the in-flight burst is abandoned.
- Request in cycle T: CALC at T+1, `o_rd_req_valid` first high at T+2.
- `o_rd_req_valid`, `o_rd_addr` and `o_rd_len` hold until ready is sampled high. Valid must not drop before that.
- A beat accepted in cycle N produces `o_buf_we`, addr and data registered at N+1.
- Last beat accepted at N gives `o_req_done` at N+2. `o_busy` drops at N+3.
- Zero-size row: `o_req_done` at T+2, with no memory or buffer activity.
- Back-to-back: a new request is accepted in the cycle after `o_req_done`.

## Test plan
- width=4, channel=2, base=0x1000, row=3 -> one burst at addr 0x1060, len 7; 8 writes to bank 3, addr 0..7, data in beat order; done 2 cycles after the last beat.
- width=10, channel=4, base=0, row=1 -> bursts at 0xA0/len 15, 0xE0/len 15, 0x120/len 7; 40 writes to bank 1; exactly one done pulse.
- `i_rd_req_ready` held low 5 cycles, then random beat-valid gaps -> request fields stable while waiting; write count and order unchanged.
- width=0 or channel=0 -> `o_rd_req_valid` never asserts; done at T+2.
- `i_req_load` pulsed during DATA with row=7 -> ignored; bank and address sequence of the original row unaffected.
- rstn asserted mid-burst, then a new request for row=2 -> outputs 0 during reset; new load completes correctly to bank 2 with no stale writes.
